// File: rtl/arm_motion_scheduler.sv
// ============================================================================
// Module  : arm_motion_scheduler
// Purpose : Slew-limited X/Y/Z command generator with source handoff, freeze
//           hold and home-on-reset. Optional soft limits: ARM_SCHED_SOFT_LIMIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_motion_scheduler #(
    parameter int DATA_WIDTH  = 10,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int UPDATE_FREQ = 50,
    parameter int MAX_STEP    = 8,
    parameter int HOME_X      = 512,
    parameter int HOME_Y      = 512,
    parameter int HOME_Z      = 512,
    parameter int LIMIT_MIN   = 64,
    parameter int LIMIT_MAX   = 960
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  select_source,
    input  logic                  freeze,
    input  logic [DATA_WIDTH-1:0] x_mem,
    input  logic [DATA_WIDTH-1:0] y_mem,
    input  logic [DATA_WIDTH-1:0] z_mem,
    input  logic [DATA_WIDTH-1:0] x_accel,
    input  logic [DATA_WIDTH-1:0] y_accel,
    input  logic [DATA_WIDTH-1:0] z_accel,
    output logic [DATA_WIDTH-1:0] x_cmd,
    output logic [DATA_WIDTH-1:0] y_cmd,
    output logic [DATA_WIDTH-1:0] z_cmd,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  update_tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        TRACK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int                    c_ticks    = CLK_FREQ / UPDATE_FREQ;
    localparam int                    c_cnt_w    = (c_ticks > 1) ? $clog2(c_ticks) : 1;
    localparam logic [c_cnt_w-1:0]    c_term     = c_cnt_w'(c_ticks - 1);
    localparam logic [DATA_WIDTH:0]   c_max_step = (DATA_WIDTH + 1)'(MAX_STEP);
    localparam logic [DATA_WIDTH-1:0] c_lim_min  = DATA_WIDTH'(LIMIT_MIN);
    localparam logic [DATA_WIDTH-1:0] c_lim_max  = DATA_WIDTH'(LIMIT_MAX);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_sel_q;
    logic [DATA_WIDTH-1:0] r_x, r_y, r_z;
    logic [DATA_WIDTH-1:0] w_raw_x, w_raw_y, w_raw_z;
    logic [DATA_WIDTH-1:0] w_tgt_x, w_tgt_y, w_tgt_z;
    logic [DATA_WIDTH-1:0] w_step_x, w_step_y, w_step_z;
    logic                  w_tick;
    logic                  w_src_chg;
    logic                  w_reach;
    logic                  w_load;

    // Difference is taken one bit wider so the sign survives; the result never wraps.
    function automatic logic [DATA_WIDTH-1:0] step_axis(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] tgt
    );
        logic signed [DATA_WIDTH:0] diff;
        logic        [DATA_WIDTH:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[DATA_WIDTH] ? 0 - diff : diff;
        if (mag <= c_max_step)
            return tgt;
        else if (diff[DATA_WIDTH])
            return cur - c_max_step[DATA_WIDTH-1:0];
        else
            return cur + c_max_step[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] clamp_axis(input logic [DATA_WIDTH-1:0] v);
        if (v < c_lim_min)
            return c_lim_min;
        else if (v > c_lim_max)
            return c_lim_max;
        else
            return v;
    endfunction

    assign w_raw_x = select_source ? x_accel : x_mem;
    assign w_raw_y = select_source ? y_accel : y_mem;
    assign w_raw_z = select_source ? z_accel : z_mem;

`ifdef ARM_SCHED_SOFT_LIMIT_EN
    assign w_tgt_x = clamp_axis(w_raw_x);
    assign w_tgt_y = clamp_axis(w_raw_y);
    assign w_tgt_z = clamp_axis(w_raw_z);
`else
    assign w_tgt_x = w_raw_x;
    assign w_tgt_y = w_raw_y;
    assign w_tgt_z = w_raw_z;
`endif

    assign w_step_x  = step_axis(r_x, w_tgt_x);
    assign w_step_y  = step_axis(r_y, w_tgt_y);
    assign w_step_z  = step_axis(r_z, w_tgt_z);
    assign w_reach   = (w_step_x == w_tgt_x) && (w_step_y == w_tgt_y) && (w_step_z == w_tgt_z);
    assign w_tick    = (r_cnt == c_term);
    assign w_src_chg = (select_source != r_sel_q);

    // IDLE, RAMP and TRACK share one tick rule: step, then TRACK iff all axes landed.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        if (freeze) begin
            w_next_state = HOLD;
        end else if (r_state == HOLD) begin
            w_next_state = RAMP;
        end else if (w_src_chg) begin
            w_next_state = RAMP;
            w_load       = w_tick;
        end else if (w_tick) begin
            w_load       = 1'b1;
            w_next_state = w_reach ? TRACK : RAMP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel_q <= select_source;
            r_x     <= DATA_WIDTH'(HOME_X);
            r_y     <= DATA_WIDTH'(HOME_Y);
            r_z     <= DATA_WIDTH'(HOME_Z);
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_sel_q <= select_source;
            if (w_load) begin
                r_x <= w_step_x;
                r_y <= w_step_y;
                r_z <= w_step_z;
            end
        end
    end

    assign x_cmd       = r_x;
    assign y_cmd       = r_y;
    assign z_cmd       = r_z;
    assign state       = r_state;
    assign busy        = (r_state == RAMP);
    assign update_tick = w_tick;

endmodule

`default_nettype wire

// File: doc/arm_motion_scheduler.md
Name: arm_motion_scheduler

Overview:
- Sits between the memory/accelerometer source mux and the servo PWM / VGA / display consumers.
- Samples the selected source's X/Y/Z target on a fixed update tick and drives slew-limited command coordinates toward it.
- Manages source handoff, freeze/hold and home-on-reset, so the servos never see a step jump when the source switches or the memory reloads.

Parameters:
- DATA_WIDTH, 10, width of every coordinate.
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- UPDATE_FREQ, 50, command update rate in Hz. Tick period is CLK_FREQ/UPDATE_FREQ cycles (integer division).
- MAX_STEP, 8, maximum per-axis change per tick (unsigned, at least 1).
- HOME_X / HOME_Y / HOME_Z, 512 each, reset command values.
- LIMIT_MIN, 64 and LIMIT_MAX, 960: soft-limit bounds, used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- select_source  in  1  0 = memory, 1 = accelerometer.
- freeze  in  1  level; holds the commands while high.
- x_mem, y_mem, z_mem  in  DATA_WIDTH each  memory targets.
- x_accel, y_accel, z_accel  in  DATA_WIDTH each  accelerometer targets.
- x_cmd, y_cmd, z_cmd  out  DATA_WIDTH each  registered command coordinates.
- state  out  2  IDLE=0, RAMP=1, TRACK=2, HOLD=3.
- busy  out  1  high exactly while state==RAMP.
- update_tick  out  1  one-cycle pulse at each update.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: x/y/z_cmd = HOME_X/Y/Z; state = IDLE; busy = 0; update_tick = 0; tick counter = 0; sel_q = select_source.
- Tick counter:
  - Counts 0..TERM where TERM = CLK_FREQ/UPDATE_FREQ-1.
  - update_tick is high during the cycle the counter equals TERM; the counter then wraps to 0.
  - The counter runs in every state and restarts only on rst.
- Target: chosen combinationally by select_source (mux), sampled only on tick cycles.
- Step rule, per axis, unsigned:
  - diff = target - cmd, computed in DATA_WIDTH+1 bits signed.
  - If |diff| <= MAX_STEP, cmd becomes target; otherwise cmd moves toward target by exactly MAX_STEP.
  - Result is always in range; no wrap is possible.
- Update timing: cmd registers update on the clock edge that ends the tick cycle, so the new values are visible the cycle after update_tick is high.
- Priority: rst > freeze > source change > tick update.
- IDLE: on a tick, apply a step and go to RAMP. If all three axes reach the target on that same step, go directly to TRACK.
- RAMP: on each tick, apply a step; when all three axes equal the target after the step, go to TRACK.
- TRACK:
  - On a tick, if every |diff| <= MAX_STEP, copy the target and stay in TRACK.
  - Otherwise apply a step and go to RAMP.
- Source change: sel_q is registered every cycle. select_source != sel_q in IDLE/TRACK/RAMP sends the FSM to RAMP on that cycle, with no cmd change until the next tick.
- HOLD:
  - freeze high in any state moves to HOLD on the next edge, and the cmd registers are held.
  - Source changes in HOLD are ignored, but sel_q still tracks.
  - On freeze low, go to RAMP. The first step is taken at the next tick.
- Simultaneous events: freeze and tick on the same cycle means no step is taken. A source change and a tick on the same cycle means a step toward the new target and state RAMP.
- Reset mid-operation: commands return to HOME on the next edge regardless of state.

Optional Feature:
- Macro: ARM_SCHED_SOFT_LIMIT_EN.
- Defined: the sampled target is clamped per axis to [LIMIT_MIN, LIMIT_MAX] before the step rule, so cmd can never leave that range.
- Undefined: the target is used raw, and LIMIT_MIN/LIMIT_MAX are unused.

Test Plan (CLK_FREQ=100, UPDATE_FREQ=10, MAX_STEP=8, HOME=512):
- Reset, no other stimulus -> cmd=512/512/512, state=0, busy=0; update_tick first high at cycle 9 after reset release, then every 10 cycles.
- select_source=0, mem target 530/512/500 -> after tick 1: 520/512/504, state RAMP, busy=1; tick 2: 528/512/500; tick 3: 530/512/500, state TRACK, busy=0.
- In TRACK, x_mem changes 530->535 -> next tick x_cmd=535, state stays TRACK. Then x_mem=600 -> x_cmd=543, state RAMP.
- Settled at x=530, switch select_source to 1 with x_accel=100 -> state RAMP immediately, cmd unchanged until the tick; x_cmd decreases by 8 per tick and reaches 100 on tick 54 (53 steps of 8 reach 106, then 100); TRACK after that.
- Assert freeze mid-ramp at x_cmd=400 for 50 cycles -> x_cmd stays 400, state HOLD, busy=0. On release: RAMP, and stepping resumes from 400 at the next tick.
- rst pulse mid-ramp -> next cycle cmd=512/512/512, state IDLE, counter 0. With ARM_SCHED_SOFT_LIMIT_EN defined and x_mem=1000 -> x_cmd settles at 960.
